// File: rtl/gray_rx_monitor.sv
// ---------------------------------------------------------------------------
// gray_rx_monitor
//
// Receives a 4-bit Gray-coded count from an upstream counter that may run in
// another clock domain. The count passes through a synchroniser, is decoded
// to binary and then checked from cycle to cycle. A clean advance of +1
// raises a step pulse. The 15 -> 0 advance also raises a wrap pulse. Any
// other non-zero change raises an err pulse.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on gray_in. Legal values are 2 and 3.
//
// Ports
//   clk       in   1  single clock; all state changes on its rising edge
//   rst_n     in   1  synchronous active-low reset
//   gray_in   in   4  Gray-coded count, may be asynchronous to clk
//   clr       in   1  synchronous clear of err_flag, lap_cnt and err_cnt
//   bin_out   out  4  decoded binary value of the synchronised count
//   valid     out  1  bin_out holds a real sample and checking is active
//   step      out  1  one-cycle pulse: value advanced by exactly +1
//   wrap      out  1  one-cycle pulse: that +1 advance was 15 -> 0
//   err       out  1  one-cycle pulse: value changed by anything but 0/+1
//   err_flag  out  1  sticky error indicator
//   lap_cnt   out  8  number of wraps, modulo 256
//   err_cnt   out  8  number of errors, saturating at 255
//
// Configuration macro
//   GRAY_RX_MONITOR_ERR_CNT_EN  when defined, err_cnt is a saturating counter.
//                               When undefined, err_cnt is tied to zero and
//                               no counter flops exist.
// ---------------------------------------------------------------------------
module gray_rx_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] gray_in,
    input  logic       clr,
    output logic [3:0] bin_out,
    output logic       valid,
    output logic       step,
    output logic       wrap,
    output logic       err,
    output logic       err_flag,
    output logic [7:0] lap_cnt,
    output logic [7:0] err_cnt
);

    // The fill counter reaches SYNC_STAGES on the edge just before valid
    // rises. For the legal depths (2 and 3), two bits are enough.
    localparam logic [1:0] FILL_LAST = 2'(SYNC_STAGES);

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] dec;
    logic [3:0] delta;

    logic [3:0] bin_out_q;
    logic       valid_q;
    logic [1:0] fill_q;
    logic       step_q,     step_d;
    logic       wrap_q,     wrap_d;
    logic       err_q,      err_d;
    logic       err_flag_q, err_flag_d;
    logic [7:0] lap_cnt_q,  lap_cnt_d;

    // Plain flop chain with no logic between the stages, so that only the
    // first flop can ever go metastable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it. It is written out flat so the vector never feeds itself.
    always_comb begin
        dec   = {sync_q[SYNC_STAGES-1][3],
                 ^sync_q[SYNC_STAGES-1][3:2],
                 ^sync_q[SYNC_STAGES-1][3:1],
                 ^sync_q[SYNC_STAGES-1][3:0]};
        delta = dec - bin_out_q;
    end

    // Event classification and statistics next state. Events are only
    // judged once valid is already high. That way the first decoded sample
    // after reset is never compared against the reset value of bin_out.
    // clr wins over a same-cycle event for the statistics, but the pulses
    // are still issued.
    always_comb begin
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        err_flag_d = err_flag_q;
        lap_cnt_d  = lap_cnt_q;

        if (valid_q) begin
            if (delta == 4'd1) begin
                step_d = 1'b1;
                wrap_d = (bin_out_q == 4'd15);
            end else if (delta != 4'd0) begin
                err_d = 1'b1;
            end
        end

        if (clr) begin
            err_flag_d = 1'b0;
            lap_cnt_d  = 8'd0;
        end else begin
            if (err_d) begin
                err_flag_d = 1'b1;
            end
            if (wrap_d) begin
                lap_cnt_d = lap_cnt_q + 8'd1;
            end
        end
    end

    // Decoded value, fill counter, pulses and statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_out_q  <= '0;
            valid_q    <= 1'b0;
            fill_q     <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
            lap_cnt_q  <= '0;
        end else begin
            bin_out_q  <= dec;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
            lap_cnt_q  <= lap_cnt_d;
            if (!valid_q) begin
                if (fill_q == FILL_LAST) begin
                    valid_q <= 1'b1;
                end else begin
                    fill_q <= fill_q + 2'd1;
                end
            end
        end
    end

`ifdef GRAY_RX_MONITOR_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // The error counter holds at 255 rather than rolling over, so a burst
    // of errors can never make the counter read a small value.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign bin_out  = bin_out_q;
    assign valid    = valid_q;
    assign step     = step_q;
    assign wrap     = wrap_q;
    assign err      = err_q;
    assign err_flag = err_flag_q;
    assign lap_cnt  = lap_cnt_q;

endmodule

// File: tb/tb_gray_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_gray_rx_monitor
//
// Directed bench for gray_rx_monitor. It runs two instances side by side,
// one with SYNC_STAGES=2 and one with SYNC_STAGES=3, on shared inputs.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// The expected err_cnt follows GRAY_RX_MONITOR_ERR_CNT_EN.
// ---------------------------------------------------------------------------
module tb_gray_rx_monitor;

`ifdef GRAY_RX_MONITOR_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       clr;

    logic [3:0] bin2, bin3;
    logic       valid2, valid3, step2, step3, wrap2, wrap3, err2, err3;
    logic       flag2, flag3;
    logic [7:0] lap2, lap3, ecnt2, ecnt3;

    int compared   = 0;
    int mismatched = 0;

    gray_rx_monitor #(.SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr),
        .bin_out(bin2), .valid(valid2), .step(step2), .wrap(wrap2),
        .err(err2), .err_flag(flag2), .lap_cnt(lap2), .err_cnt(ecnt2)
    );

    gray_rx_monitor #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr),
        .bin_out(bin3), .valid(valid3), .step(step3), .wrap(wrap3),
        .err(err3), .err_flag(flag3), .lap_cnt(lap3), .err_cnt(ecnt3)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    // Hold reset for a few edges; every output of both instances must be 0.
    task automatic test_reset();
        rst_n   = 1'b0;
        clr     = 1'b0;
        gray_in = 4'b0000;
        repeat (3) tick();
        compared++;
        if ({bin2, valid2, step2, wrap2, err2, flag2, lap2, ecnt2} !== 28'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_ss2: got %h want 0",
                     {bin2, valid2, step2, wrap2, err2, flag2, lap2, ecnt2});
        end
        compared++;
        if ({bin3, valid3, step3, wrap3, err3, flag3, lap3, ecnt3} !== 28'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_ss3: got %h want 0",
                     {bin3, valid3, step3, wrap3, err3, flag3, lap3, ecnt3});
        end
    endtask

    // Drive a free-running Gray counter for 40 edges. Value k-1 is applied
    // before edge k. With a lag L (3 or 4), bin_out reads k-L once valid,
    // and step follows one edge later.
    task automatic test_count();
        int wraps2 = 0;
        int wraps3 = 0;
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            logic       ev2, es2, ew2, ev3, es3, ew3;
            logic [3:0] eb2, eb3;
            gray_in = gray4(k - 1);
            tick();
            ev2 = (k >= 3);
            eb2 = (k >= 3) ? 4'((k - 3) % 16) : 4'd0;
            es2 = (k >= 4);
            ew2 = (k >= 4) && (((k - 3) % 16) == 0);
            ev3 = (k >= 4);
            eb3 = (k >= 4) ? 4'((k - 4) % 16) : 4'd0;
            es3 = (k >= 5);
            ew3 = (k >= 5) && (((k - 4) % 16) == 0);
            if (wrap2) wraps2++;
            if (wrap3) wraps3++;
            compared++;
            if ({valid2, bin2, step2, wrap2, err2} !== {ev2, eb2, es2, ew2, 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL count_ss2 edge %0d: got v=%b b=%0d s=%b w=%b e=%b want v=%b b=%0d s=%b w=%b e=0",
                         k, valid2, bin2, step2, wrap2, err2, ev2, eb2, es2, ew2);
            end
            compared++;
            if ({valid3, bin3, step3, wrap3, err3} !== {ev3, eb3, es3, ew3, 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL count_ss3 edge %0d: got v=%b b=%0d s=%b w=%b e=%b want v=%b b=%0d s=%b w=%b e=0",
                         k, valid3, bin3, step3, wrap3, err3, ev3, eb3, es3, ew3);
            end
        end
        compared++;
        if (wraps2 != 2 || lap2 !== 8'd2 || flag2 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL laps_ss2: got wraps=%0d lap=%0d flag=%b want 2/2/0", wraps2, lap2, flag2);
        end
        compared++;
        if (wraps3 != 2 || lap3 !== 8'd2) begin
            mismatched++;
            $display("[TB] FAIL laps_ss3: got wraps=%0d lap=%0d want 2/2", wraps3, lap3);
        end
    endtask

    // Alternate between binary 0 and 8 so that every edge is an error,
    // for 300 edges. Then assert clr on an edge that also carries an error.
    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 1) ? 4'b1100 : 4'b0000;
            tick();
        end
        compared++;
        if ({err2, flag2, step2} !== 3'b110 || lap2 !== 8'd2 ||
            ecnt2 !== (CNT_EN ? 8'd255 : 8'd0)) begin
            mismatched++;
            $display("[TB] FAIL saturate: got err=%b flag=%b step=%b lap=%0d cnt=%0d want 1/1/0/2/%0d",
                     err2, flag2, step2, lap2, ecnt2, CNT_EN ? 255 : 0);
        end
        clr     = 1'b1;
        gray_in = 4'b1100;
        tick();
        clr = 1'b0;
        compared++;
        if ({err2, flag2, valid2} !== 3'b101 || lap2 !== 8'd0 || ecnt2 !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL clr_ss2: got err=%b flag=%b valid=%b lap=%0d cnt=%0d want 1/0/1/0/0",
                     err2, flag2, valid2, lap2, ecnt2);
        end
        compared++;
        if ({err3, flag3} !== 2'b10 || lap3 !== 8'd0 || ecnt3 !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL clr_ss3: got err=%b flag=%b lap=%0d cnt=%0d want 1/0/0/0",
                     err3, flag3, lap3, ecnt3);
        end
        gray_in = 4'b0000;
        tick();
        compared++;
        if (flag2 !== 1'b1 || ecnt2 !== (CNT_EN ? 8'd1 : 8'd0)) begin
            mismatched++;
            $display("[TB] FAIL post_clr: got flag=%b cnt=%0d want 1/%0d", flag2, ecnt2, CNT_EN ? 1 : 0);
        end
    endtask

    // Reset with the count at 1, then jump to binary 4 (Gray 0110).
    // The error should reach the SS=2 output two edges after capture and the
    // SS=3 output one edge later.
    task automatic test_jump();
        gray_in = 4'b0001;
        rst_n   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        compared++;
        if ({valid2, bin2, err2, flag2} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL jump_pre: got v=%b b=%0d e=%b f=%b want 1/1/0/0", valid2, bin2, err2, flag2);
        end
        gray_in = 4'b0110;
        repeat (2) tick();
        compared++;
        if (err2 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL jump_early: got err=%b want 0", err2);
        end
        tick();
        compared++;
        if ({err2, step2, flag2, bin2} !== {1'b1, 1'b0, 1'b1, 4'd4} ||
            ecnt2 !== (CNT_EN ? 8'd1 : 8'd0) || err3 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL jump_ss2: got e=%b s=%b f=%b b=%0d cnt=%0d e3=%b want 1/0/1/4/%0d/0",
                     err2, step2, flag2, bin2, ecnt2, err3, CNT_EN ? 1 : 0);
        end
        tick();
        compared++;
        if ({err2, flag2, err3, step3, flag3, bin3} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4}) begin
            mismatched++;
            $display("[TB] FAIL jump_ss3: got e2=%b f2=%b e3=%b s3=%b f3=%b b3=%0d want 0/1/1/0/1/4",
                     err2, flag2, err3, step3, flag3, bin3);
        end
        tick();
        compared++;
        if ({err3, flag3} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL jump_ss3_end: got e3=%b f3=%b want 0/1", err3, flag3);
        end
    endtask

    // Hold Gray 1010 (binary 12) and pulse reset mid-run. The pipeline must
    // refill with no step and no error.
    task automatic test_midreset();
        gray_in = 4'b1010;
        repeat (6) tick();
        compared++;
        if ({valid2, bin2, flag2} !== {1'b1, 4'd12, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL midrst_pre: got v=%b b=%0d f=%b want 1/12/1", valid2, bin2, flag2);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        compared++;
        if ({bin2, valid2, step2, wrap2, err2, flag2, lap2, ecnt2,
             bin3, valid3, step3, wrap3, err3, flag3, lap3, ecnt3} !== 56'd0) begin
            mismatched++;
            $display("[TB] FAIL midrst_zero: got %h want 0",
                     {bin2, valid2, step2, wrap2, err2, flag2, lap2, ecnt2,
                      bin3, valid3, step3, wrap3, err3, flag3, lap3, ecnt3});
        end
        for (int k = 1; k <= 5; k++) begin
            logic       ev2, ev3;
            logic [3:0] eb2, eb3;
            tick();
            ev2 = (k >= 3);
            eb2 = (k >= 3) ? 4'd12 : 4'd0;
            ev3 = (k >= 4);
            eb3 = (k >= 4) ? 4'd12 : 4'd0;
            compared++;
            if ({valid2, bin2, step2, err2, valid3, bin3, step3, err3} !==
                {ev2, eb2, 2'b00, ev3, eb3, 2'b00}) begin
                mismatched++;
                $display("[TB] FAIL midrst_edge %0d: got v2=%b b2=%0d s2=%b e2=%b v3=%b b3=%0d s3=%b e3=%b want v2=%b b2=%0d v3=%b b3=%0d s=e=0",
                         k, valid2, bin2, step2, err2, valid3, bin3, step3, err3, ev2, eb2, ev3, eb3);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        gray_in = 4'b0000;
        test_reset();
        test_count();
        test_saturate();
        test_jump();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
